ticket_dispense_arbiter: RTL and testbench

Round-robin arbiter and sequencer that lets several ticket booths share one ticket dispenser and one change chute. Each booth presents a destination choice and the cash it holds. The block grants one booth at a time and validates the fare. It then waits for the dispenser mechanism, pulses the matching ticket line, and returns change or a full refund. It sits between the per-booth coin front-ends and the shared dispensing hardware.

---
 rtl/ticket_dispense_arbiter_if.sv | 28 ++
 rtl/ticket_dispense_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ticket_dispense_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ticket_dispense_arbiter_if.sv
// Booth-side and dispenser-side signals shared by the ticket dispense arbiter.
// The slave modport is the arbiter's view; master is the booth/dispenser side.
interface ticket_dispense_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] dest;
  logic [5*N_REQ-1:0] paid;
  logic               disp_ready;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               howrah;
  logic               manikaran;
  logic               esplanade;
  logic [4:0]         change_out;
  logic               change_valid;
  logic               err;

  modport slave (
    input  req, dest, paid, disp_ready,
    output gnt, done, howrah, manikaran, esplanade, change_out, change_valid, err
  );

  modport master (
    output req, dest, paid, disp_ready,
    input  gnt, done, howrah, manikaran, esplanade, change_out, change_valid, err
  );
endinterface

// File: rtl/ticket_dispense_arbiter.sv
// Round-robin arbiter/sequencer sharing one ticket dispenser and change chute
// among N_REQ booths: grant, fare check, dispense, then change or refund.
module ticket_dispense_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DISP_CYCLES = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  ticket_dispense_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WAIT_RDY, S_DISPENSE, S_SETTLE, S_REFUND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [1:0]    dest_q, dest_d;
  logic [4:0]    paid_q, paid_d;
  logic [7:0]    timer_q, timer_d;
  logic [3:0]    dcnt_q, dcnt_d;

  logic [IW-1:0] win;
  logic [1:0]    win_dest;
  logic [4:0]    win_paid;
  logic [4:0]    fare;

  function automatic logic [4:0] fare_of(input logic [1:0] d);
    case (d)
      2'b01:   fare_of = 5'd10;
      2'b10:   fare_of = 5'd15;
      2'b11:   fare_of = 5'd25;
      default: fare_of = 5'd0;
    endcase
  endfunction

  assign fare = fare_of(dest_q);

  // First requesting booth at or above ptr, wrapping around.
  always_comb begin : pick
    logic [IW:0] sum;
    logic        found;
    sum      = '0;
    found    = 1'b0;
    win      = ptr_q;
    win_dest = '0;
    win_paid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && bus.req[sum[IW-1:0]]) begin
        found    = 1'b1;
        win      = sum[IW-1:0];
        win_dest = bus.dest[2*sum[IW-1:0] +: 2];
        win_paid = bus.paid[5*sum[IW-1:0] +: 5];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    dest_d  = dest_q;
    paid_d  = paid_q;
    timer_d = timer_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          sel_d   = win;
          dest_d  = win_dest;
          paid_d  = win_paid;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dest_q == 2'b00 || paid_q < fare) begin
          state_d = S_REFUND;
        end else begin
          timer_d = '0;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        // Readiness wins over a timer expiring in the same cycle.
        if (bus.disp_ready) begin
          dcnt_d  = 4'(DISP_CYCLES - 1);
          state_d = S_DISPENSE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == 8'(TIMEOUT)) state_d = S_REFUND;
        end
      end
      S_DISPENSE: begin
        if (dcnt_q == '0) state_d = S_SETTLE;
        else              dcnt_d  = dcnt_q - 4'd1;
      end
      S_SETTLE: state_d = S_DONE;
      S_REFUND: state_d = S_DONE;
      S_DONE: begin
        ptr_d   = (sel_q == IW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      dest_q  <= '0;
      paid_q  <= '0;
      timer_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      dest_q  <= dest_d;
      paid_q  <= paid_d;
      timer_q <= timer_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Outputs decode only registered state and latched booth data.
  always_comb begin
    bus.gnt          = '0;
    bus.done         = '0;
    bus.howrah       = 1'b0;
    bus.manikaran    = 1'b0;
    bus.esplanade    = 1'b0;
    bus.change_out   = '0;
    bus.change_valid = 1'b0;
    bus.err          = 1'b0;
    if (state_q != S_IDLE) bus.gnt[sel_q] = 1'b1;
    case (state_q)
      S_DISPENSE: begin
        bus.howrah    = (dest_q == 2'b01);
        bus.manikaran = (dest_q == 2'b10);
        bus.esplanade = (dest_q == 2'b11);
      end
      S_SETTLE: begin
        bus.change_out   = paid_q - fare;
        bus.change_valid = 1'b1;
      end
      S_REFUND: begin
        bus.change_out   = paid_q;
        bus.change_valid = 1'b1;
        bus.err          = 1'b1;
      end
      S_DONE:  bus.done[sel_q] = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ticket_dispense_arbiter.sv
// Scoreboard bench: stimulus pushes the expected per-service record, a
// monitor rebuilds each service from the outputs and checks it at done.
module tb_ticket_dispense_arbiter;
  localparam int N = 4, DC = 3, TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ticket_dispense_arbiter_if #(.N_REQ(N)) bus ();
  ticket_dispense_arbiter #(.N_REQ(N), .DISP_CYCLES(DC), .TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // line: 0 none, 1 howrah, 2 manikaran, 3 esplanade; t_*: cycles after first gnt
  typedef struct {
    int booth; int line; int tcnt; int chg; int err; int t_tick; int t_chg; int t_done;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int b, input int ln, input int tc, input int ch,
                      input int er, input int tt, input int tch, input int td);
    exp_t e;
    e.booth = b; e.line = ln; e.tcnt = tc; e.chg = ch; e.err = er;
    e.t_tick = tt; e.t_chg = tch; e.t_done = td;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0, t0 = 0, booth = 0, line = 0, tcnt = 0, t_tick = -1;
  int chg = -1, err_s = 0, t_chg = -1, last_done = -100;
  bit active = 1'b0;

  always @(negedge clk) begin
    int   nt, lv, gi;
    exp_t e;
    cyc++;
    nt = int'(bus.howrah) + int'(bus.manikaran) + int'(bus.esplanade);
    gi = 0;
    for (int i = 0; i < N; i++) if (bus.gnt[i]) gi = i;
    if (bus.gnt != 0) chk("gnt_onehot", int'($onehot(bus.gnt)), 1);
    if (!active && bus.gnt != 0) begin
      chk("idle_gap", int'(cyc - last_done >= 2), 1);
      active = 1'b1; booth = gi; t0 = cyc; line = 0; tcnt = 0;
      t_tick = -1; chg = -1; err_s = 0; t_chg = -1;
    end else if (active && bus.gnt != 0) begin
      chk("gnt_stable", int'(bus.gnt), 1 << booth);
    end
    if (nt > 1) chk("one_line", nt, 1);
    if (nt == 1) begin
      lv = bus.howrah ? 1 : (bus.manikaran ? 2 : 3);
      if (!active) chk("line_without_gnt", nt, 0);
      else if (tcnt == 0) begin
        line = lv; t_tick = cyc - t0; tcnt = 1;
      end else begin
        chk("line_same", lv, line);
        chk("line_contig", cyc - t0, t_tick + tcnt);
        tcnt++;
      end
    end
    if (!bus.change_valid) chk("chg_idle", int'(bus.change_out) + int'(bus.err), 0);
    else if (!active) chk("chg_without_gnt", int'(bus.change_valid), 0);
    else begin
      chk("chg_once", t_chg, -1);
      chg = int'(bus.change_out); err_s = int'(bus.err); t_chg = cyc - t0;
    end
    if (bus.done != 0) begin
      if (!active) chk("done_without_gnt", int'(bus.done), 0);
      else begin
        chk("done_matches_gnt", int'(bus.done), int'(bus.gnt));
        if (sb.size() == 0) chk("unexpected_done_booth", booth, -1);
        else begin
          e = sb.pop_front();
          chk("booth", booth, e.booth);
          chk("line", line, e.line);
          chk("line_cycles", tcnt, e.tcnt);
          chk("change", chg, e.chg);
          chk("err", err_s, e.err);
          chk("t_line", t_tick, e.t_tick);
          chk("t_change", t_chg, e.t_chg);
          chk("t_done", cyc - t0, e.t_done);
        end
        active = 1'b0; last_done = cyc;
      end
    end else if (active && bus.gnt == 0) begin
      active = 1'b0;  // service aborted by reset
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_booth(input int b, input logic [1:0] d, input logic [4:0] p);
    bus.dest[2*b +: 2] = d;
    bus.paid[5*b +: 5] = p;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, int'(bus.gnt), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_lines"}, int'(bus.howrah) + int'(bus.manikaran) + int'(bus.esplanade), 0);
    chk({tag, "_change"}, int'(bus.change_out), 0);
    chk({tag, "_cv_err"}, int'(bus.change_valid) + int'(bus.err), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.disp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int got = 0, k = 0;
    while (got < n && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.done != 0) got++;
    end
    chk(name, got, n);
  endtask

  task automatic load_all_valid();
    set_booth(0, 2'b01, 5'd20);
    set_booth(1, 2'b10, 5'd15);
    set_booth(2, 2'b11, 5'd31);
    set_booth(3, 2'b01, 5'd10);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.req = '0; bus.dest = '0; bus.paid = '0; bus.disp_ready = 1'b0;

    // booth 0 howrah, paid 15: change 5
    do_reset();
    set_booth(0, 2'b01, 5'd15);
    bus.disp_ready = 1'b1;
    push(0, 1, 3, 5, 0, 2, 5, 6);
    bus.req = 4'b0001;
    wait_dones(1, 40, "t1_done_seen");
    bus.req = '0;
    repeat (3) @(negedge clk);

    // booth 2 manikaran underpaid: refund 10
    do_reset();
    set_booth(2, 2'b10, 5'd10);
    bus.disp_ready = 1'b1;
    push(2, 0, 0, 10, 1, -1, 1, 2);
    bus.req = 4'b0100;
    wait_dones(1, 40, "t2_done_seen");
    bus.req = '0;
    repeat (3) @(negedge clk);

    // booth 1 esplanade, dispenser never ready: timeout refund 25
    do_reset();
    set_booth(1, 2'b11, 5'd25);
    push(1, 0, 0, 25, 1, -1, 16, 17);
    bus.req = 4'b0010;
    wait_dones(1, 60, "t3_done_seen");
    bus.req = '0;
    repeat (3) @(negedge clk);

    // same, ready rises in the last waiting cycle: dispense, change 0
    do_reset();
    set_booth(1, 2'b11, 5'd25);
    push(1, 3, 3, 0, 0, 16, 19, 20);
    bus.req = 4'b0010;
    repeat (16) @(negedge clk);
    bus.disp_ready = 1'b1;
    wait_dones(1, 60, "t4_done_seen");
    bus.req = '0;
    repeat (3) @(negedge clk);

    // all booths requesting: round robin 0,1,2,3,0
    do_reset();
    load_all_valid();
    bus.disp_ready = 1'b1;
    push(0, 1, 3, 10, 0, 2, 5, 6);
    push(1, 2, 3, 0, 0, 2, 5, 6);
    push(2, 3, 3, 6, 0, 2, 5, 6);
    push(3, 1, 3, 0, 0, 2, 5, 6);
    push(0, 1, 3, 10, 0, 2, 5, 6);
    bus.req = 4'b1111;
    wait_dones(5, 200, "t5_dones_seen");
    bus.req = '0;
    repeat (3) @(negedge clk);

    // reset while booth 3 dispenses; next grant restarts at booth 0
    do_reset();
    load_all_valid();
    bus.disp_ready = 1'b1;
    push(0, 1, 3, 10, 0, 2, 5, 6);
    push(1, 2, 3, 0, 0, 2, 5, 6);
    push(2, 3, 3, 6, 0, 2, 5, 6);
    push(0, 1, 3, 10, 0, 2, 5, 6);
    bus.req = 4'b1111;
    k = 0;
    while (!(bus.gnt[3] && (bus.howrah || bus.manikaran || bus.esplanade)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_b3_dispense", int'(k < 200), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("midreset");
    rst = 1'b0;
    wait_dones(1, 40, "t6_done_after_reset");
    bus.req = '0;
    repeat (3) @(negedge clk);

    // invalid destination, nothing paid: refund 0 with err
    do_reset();
    set_booth(3, 2'b00, 5'd0);
    bus.disp_ready = 1'b1;
    push(3, 0, 0, 0, 1, -1, 1, 2);
    bus.req = 4'b1000;
    wait_dones(1, 40, "t7_done_seen");
    bus.req = '0;
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
